pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable, bubble and flush inputs plus the PC write enable and redirect select. It resolves load-use hazards, taken branch/jump redirects resolved in EX, and multi-cycle data-memory waits (with timeout). It keeps saturating event counters for performance debug.

## Interface
- CNT_W, 16, width of each event counter
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (≥1)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs_ID, rt_ID  in  5 each  source register numbers of instruction in ID
- usesRt_ID  in  1  instruction in ID reads rt
- MemRead_EX  in  1  instruction in EX is a load
- writeAddr_EX  in  5  destination register of instruction in EX
- Branch_EX, Zero_EX, Jump_EX  in  1 each  branch/jump resolution in EX
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  out  1 each  register write enables
- IDEXBubble  out  1  load zeros into ID/EX control fields
- IFIDFlush, IDEXFlush  out  1 each  squash younger instructions
- redirect  out  1  PC mux selects branch/jump target
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  saturating event counters

## Operation
- States: RUN, MEM_WAIT, ERR. State, counters, timeout counter and mem_err are registered. All control outputs are combinational from state and current inputs.
- taken = Jump_EX | (Branch_EX & Zero_EX).
- lu_hazard = MemRead_EX & writeAddr_EX≠0 & (writeAddr_EX==rs_ID | (usesRt_ID & writeAddr_EX==rt_ID)).
- Default (no event): all four write enables 1; bubble, flushes and redirect 0.
- RUN, priority order:
  1. mem_req & !mem_ready → freeze: all write enables 0; bubble, flush and redirect 0. Next state MEM_WAIT; timeout counter ← 1; wait_cnt++.
  2. taken → redirect=1, IFIDFlush=1, IDEXFlush=1, write enables 1; flush_cnt++. lu_hazard is ignored, because its consumer is squashed.
  3. lu_hazard → PCWrite=0, IFIDWrite=0, IDEXBubble=1; IDEXWrite and EXMEMWrite stay 1; stall_cnt++.
- MEM_WAIT:
  - mem_ready=1: evaluate exactly as RUN items 2–3 this cycle; next state RUN.
  - mem_ready=0 and timeout counter < MEM_TIMEOUT: freeze, wait_cnt++, timeout counter++.
  - mem_ready=0 and timeout counter == MEM_TIMEOUT: freeze; mem_err←1; next state ERR.
- ERR: freeze permanently; counters hold; leave only via rst.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- Frozen cycles never increment stall_cnt or flush_cnt.
- Reset (asynchronous, any state, mid-wait included) → state RUN, all counters 0, timeout counter 0, mem_err 0. While rst=1, all write enables, bubble, flushes and redirect are forced 0.

## Timing
- Zero-cycle decision latency: outputs respond in the same cycle as the inputs. The pipeline registers act on the next rising edge.
- Load-use costs exactly 1 bubble cycle. On the next edge the load advances to MEM and lu_hazard drops.
- Taken branch/jump costs 2 squashed instructions with a single flush cycle. redirect is asserted in the same cycle as the flushes.
- A memory access that completes in its first cycle (mem_req & mem_ready) produces no freeze and no wait_cnt increment.
- A taken branch in EX during a freeze is held in EX. It redirects in the cycle mem_ready rises.
- A load-use hazard during a freeze is likewise deferred to the release cycle.
- Registered outputs (counters, mem_err) update on the rising edge following the qualifying cycle.

## Test plan
- Load-use: MemRead_EX=1, writeAddr_EX=8, rs_ID=8, no mem_req → PCWrite=0, IFIDWrite=0, IDEXBubble=1 for one cycle, then all enables 1; stall_cnt=1. Repeat with writeAddr_EX=0 → no stall.
- rt gating: writeAddr_EX=9, rt_ID=9, usesRt_ID=0 → no stall; with usesRt_ID=1 → stall.
- Branch taken: Branch_EX=1, Zero_EX=1, lu_hazard also true → redirect=1, IFIDFlush=1, IDEXFlush=1, PCWrite=1, no bubble; flush_cnt=1, stall_cnt=0. With Zero_EX=0 → no flush.
- Memory wait: mem_req=1, mem_ready low for 3 cycles, Jump_EX=1 held throughout → 3 freeze cycles with all enables 0; in the release cycle, redirect and both flushes =1; wait_cnt=3, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_err=1 after cycle 5, state ERR, all enables stay 0 even after mem_ready=1. Then assert rst mid-ERR → mem_err=0, all counters 0, normal RUN behaviour.
- Saturation: CNT_W=2, 5 consecutive load-use hazards → stall_cnt sticks at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait freezes with timeout, and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             usesRt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       writeAddr_EX,
  input  logic             Branch_EX,
  input  logic             Zero_EX,
  input  logic             Jump_EX,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int unsigned     TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t          state, state_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            set_err, inc_wait;
  logic            taken, lu_hazard, frozen, act_taken, act_lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign taken     = Jump_EX | (Branch_EX & Zero_EX);
  assign lu_hazard = MemRead_EX & (writeAddr_EX != 5'd0) &
                     ((writeAddr_EX == rs_ID) | (usesRt_ID & (writeAddr_EX == rt_ID)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      to_cnt <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    to_cnt_nx = to_cnt;
    set_err   = 1'b0;
    inc_wait  = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nx  = MEM_WAIT;
          to_cnt_nx = TO_W'(1);
          inc_wait  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nx = RUN;
        end else if (to_cnt < TO_MAX) begin
          to_cnt_nx = to_cnt + TO_W'(1);
          inc_wait  = 1'b1;
        end else begin
          state_nx = ERR;
          set_err  = 1'b1;
        end
      end
      ERR: ;
      default: state_nx = RUN;
    endcase
  end

  // Redirect/stall decisions made during a freeze are deferred, so they are
  // only acted on (and counted) in an unfrozen cycle.
  always_comb begin
    frozen = 1'b1;
    unique case (state)
      RUN:      frozen = mem_req & ~mem_ready;
      MEM_WAIT: frozen = ~mem_ready;
      ERR:      frozen = 1'b1;
      default:  frozen = 1'b1;
    endcase
    act_taken = ~frozen & taken;
    act_lu    = ~frozen & ~taken & lu_hazard;

    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    redirect   = 1'b0;
    if (rst || frozen) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (act_taken) begin
      redirect  = 1'b1;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (act_lu) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (set_err)   mem_err   <= 1'b1;
      if (act_lu)    stall_cnt <= sat_inc(stall_cnt);
      if (act_taken) flush_cnt <= sat_inc(flush_cnt);
      if (inc_wait)  wait_cnt  <= sat_inc(wait_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned TO    = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_ID, rt_ID, writeAddr_EX;
  logic usesRt_ID, MemRead_EX, Branch_EX, Zero_EX, Jump_EX, mem_req, mem_ready;
  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, IFIDFlush, IDEXFlush, redirect;
  logic mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: whether the pipeline is waiting on memory, how long, whether dead.
  bit m_waiting, m_dead;
  int m_tc, m_stall, m_flush, m_wait;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .usesRt_ID(usesRt_ID),
    .MemRead_EX(MemRead_EX), .writeAddr_EX(writeAddr_EX), .Branch_EX(Branch_EX),
    .Zero_EX(Zero_EX), .Jump_EX(Jump_EX), .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .redirect(redirect),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit is_taken();
    return Jump_EX || (Branch_EX && Zero_EX);
  endfunction

  function automatic bit is_lu();
    if (!MemRead_EX || writeAddr_EX == 0) return 1'b0;
    return (writeAddr_EX == rs_ID) || (usesRt_ID && writeAddr_EX == rt_ID);
  endfunction

  function automatic bit is_frozen();
    if (m_dead) return 1'b1;
    if (m_waiting) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, IFIDFlush, IDEXFlush, redirect}
  function automatic logic [7:0] exp_ctl();
    if (rst || is_frozen()) return 8'b0000_0000;
    if (is_taken())         return 8'b1111_0111;
    if (is_lu())            return 8'b0011_1000;
    return 8'b1111_0000;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_dead = 0; m_tc = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic model_edge();
    if (m_dead) return;
    if (m_waiting && !mem_ready) begin
      if (m_tc < TO) begin m_tc++; m_wait = sat(m_wait); end
      else begin m_dead = 1; m_waiting = 0; end
      return;
    end
    if (!m_waiting && mem_req && !mem_ready) begin
      m_waiting = 1; m_tc = 1; m_wait = sat(m_wait);
      return;
    end
    m_waiting = 0;
    if (is_taken())   m_flush = sat(m_flush);
    else if (is_lu()) m_stall = sat(m_stall);
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic [31:0] exp_reg;
    #1;
    if (rst) model_reset();
    chk({tag, ":ctl"},
        {24'd0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, IFIDFlush, IDEXFlush, redirect},
        {24'd0, exp_ctl()});
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    exp_reg = {22'd0, m_dead, CNT_W'(m_stall), CNT_W'(m_flush), CNT_W'(m_wait)};
    chk({tag, ":reg"}, {22'd0, mem_err, stall_cnt, flush_cnt, wait_cnt}, exp_reg);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rs_ID = 5'd1; rt_ID = 5'd2; usesRt_ID = 0; MemRead_EX = 0; writeAddr_EX = 5'd3;
    Branch_EX = 0; Zero_EX = 0; Jump_EX = 0; mem_req = 0; mem_ready = 0;
  endtask

  int lowrun;

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(negedge clk);
    cycle("reset");
    cycle("reset");
    rst = 0;
    cycle("idle");

    // load-use on rs, then release
    MemRead_EX = 1; writeAddr_EX = 5'd8; rs_ID = 5'd8;
    cycle("lu_rs");
    MemRead_EX = 0;
    cycle("lu_after");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // r0 never creates a hazard
    MemRead_EX = 1; writeAddr_EX = 5'd0; rs_ID = 5'd0;
    cycle("lu_r0");
    // rt gating
    writeAddr_EX = 5'd9; rs_ID = 5'd1; rt_ID = 5'd9; usesRt_ID = 0;
    cycle("rt_unused");
    usesRt_ID = 1;
    cycle("rt_used");
    chk("rt_stall_cnt", 32'(stall_cnt), 32'd2);

    // taken branch overrides load-use
    Branch_EX = 1; Zero_EX = 1;
    cycle("br_taken_lu");
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd2);
    idle();
    Branch_EX = 1; Zero_EX = 0;
    cycle("br_not_taken");

    // memory wait with a jump held in EX
    idle();
    Jump_EX = 1; mem_req = 1; mem_ready = 0;
    repeat (3) cycle("mw_freeze");
    mem_ready = 1;
    cycle("mw_release");
    chk("mw_wait_cnt", 32'(wait_cnt), 32'd3);
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd2);
    idle();
    mem_req = 1; mem_ready = 1;
    cycle("mw_fast");

    // timeout into ERR, then asynchronous recovery
    idle();
    mem_req = 1; mem_ready = 0;
    repeat (5) cycle("to_wait");
    chk("to_mem_err", 32'(mem_err), 32'd1);
    mem_ready = 1;
    repeat (2) cycle("err_hold");
    rst = 1;
    cycle("err_rst");
    chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    rst = 0; idle();
    cycle("post_rst");

    // saturation of stall_cnt
    MemRead_EX = 1; writeAddr_EX = 5'd5; rs_ID = 5'd5;
    repeat (CMAX + 2) cycle("sat_lu");
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));

    // randomized traffic
    idle();
    lowrun = 0;
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      rs_ID        = 5'($urandom_range(0, 3));
      rt_ID        = 5'($urandom_range(0, 3));
      writeAddr_EX = 5'($urandom_range(0, 3));
      usesRt_ID    = 1'($urandom);
      MemRead_EX   = ($urandom_range(0, 2) == 0);
      Branch_EX    = ($urandom_range(0, 3) == 0);
      Zero_EX      = 1'($urandom);
      Jump_EX      = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      if (lowrun > 0) begin
        mem_ready = 0;
        lowrun--;
      end else begin
        if ($urandom_range(0, 9) == 0) lowrun = $urandom_range(1, 6);
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
